// File: rtl/round_test.sv
// BORON single decryption round: inverse mix, rotate, shuffle, S-box, key add.
// The round result is registered; out_valid follows in_valid by one cycle.
module round_test (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [63:0] Current_Text,
  input  logic [79:0] Key,
  output logic [63:0] Updated_Text,
  output logic        out_valid
);

  logic [63:0] r_text;
  logic        r_valid;

  logic [15:0] w_a, w_b, w_c, w_d;
  logic [15:0] w_m0, w_m1, w_m2, w_m3;
  logic [15:0] w_r0, w_r1, w_r2, w_r3;
  logic [63:0] w_rot;
  logic [63:0] w_shuf;
  logic [63:0] w_sub;
  logic [63:0] w_round;
  logic        w_unused_key;

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hA;
      4'h1: y = 4'h3;
      4'h2: y = 4'h9;
      4'h3: y = 4'hE;
      4'h4: y = 4'h1;
      4'h5: y = 4'hD;
      4'h6: y = 4'hF;
      4'h7: y = 4'h4;
      4'h8: y = 4'hC;
      4'h9: y = 4'h5;
      4'hA: y = 4'h7;
      4'hB: y = 4'h2;
      4'hC: y = 4'h6;
      4'hD: y = 4'h8;
      4'hE: y = 4'h0;
      4'hF: y = 4'hB;
    endcase
    return y;
  endfunction

  assign w_a = Current_Text[63:48];
  assign w_b = Current_Text[47:32];
  assign w_c = Current_Text[31:16];
  assign w_d = Current_Text[15:0];

  // W0/W1 must be recovered first; W2/W3 reuse them
  assign w_m0 = w_d ^ w_a;
  assign w_m1 = w_c ^ w_b;
  assign w_m2 = w_b ^ w_m0;
  assign w_m3 = w_a ^ w_m1;

  assign w_r0 = {w_m0[0],   w_m0[15:1]};
  assign w_r1 = {w_m1[3:0], w_m1[15:4]};
  assign w_r2 = {w_m2[6:0], w_m2[15:7]};
  assign w_r3 = {w_m3[8:0], w_m3[15:9]};

  assign w_rot = {w_r3, w_r2, w_r1, w_r0};

  assign w_shuf = {
    w_rot[15:8],
    w_rot[55:48],
    w_rot[31:24],
    w_rot[47:40],
    w_rot[7:0],
    w_rot[63:56],
    w_rot[23:16],
    w_rot[39:32]
  };

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    assign w_sub[4*g +: 4] = inv_sbox(w_shuf[4*g +: 4]);
  end

  assign w_round = w_sub ^ Key[63:0];

  // Upper key bits belong to the schedule outside this block
  assign w_unused_key = ^Key[79:64];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_text  <= 64'h0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) r_text <= w_round;
    end
  end

  assign Updated_Text = r_text;
  assign out_valid    = r_valid;

endmodule

// File: tb/tb_round_test.sv
// Bench for round_test: directed vectors plus forward-model round trips.
// Forward round is modelled here; the DUT must undo it exactly.
module tb_round_test;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] Current_Text;
  logic [79:0] Key;
  logic [63:0] Updated_Text;
  logic        out_valid;

  int checks;
  int failures;

  round_test dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .Current_Text (Current_Text),
    .Key          (Key),
    .Updated_Text (Updated_Text),
    .out_valid    (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] text;
    logic [79:0] key;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hE;
      4'h1: y = 4'h4;
      4'h2: y = 4'hB;
      4'h3: y = 4'h1;
      4'h4: y = 4'h7;
      4'h5: y = 4'h9;
      4'h6: y = 4'hC;
      4'h7: y = 4'hA;
      4'h8: y = 4'hD;
      4'h9: y = 4'h2;
      4'hA: y = 4'h0;
      4'hB: y = 4'hF;
      4'hC: y = 4'h8;
      4'hD: y = 4'h5;
      4'hE: y = 4'h3;
      default: y = 4'h6;
    endcase
    return y;
  endfunction

  function automatic logic [15:0] rotl16(input logic [15:0] w, input int n);
    logic [31:0] t;
    t = {w, w} << n;
    return t[31:16];
  endfunction

  function automatic logic [63:0] encrypt(input logic [63:0] x,
                                          input logic [79:0] k);
    logic [63:0] s, p;
    logic [7:0]  b[8];
    logic [15:0] w0, w1, w2, w3;
    s = x ^ k[63:0];
    for (int i = 0; i < 16; i++) s[4*i +: 4] = sbox(s[4*i +: 4]);
    for (int i = 0; i < 8; i++) b[i] = s[8*i +: 8];
    p = {b[2], b[6], b[4], b[0], b[5], b[1], b[7], b[3]};
    w3 = rotl16(p[63:48], 9);
    w2 = rotl16(p[47:32], 7);
    w1 = rotl16(p[31:16], 4);
    w0 = rotl16(p[15:0], 1);
    w3 = w3 ^ w1;
    w2 = w2 ^ w0;
    w1 = w1 ^ w2;
    w0 = w0 ^ w3;
    return {w3, w2, w1, w0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk64(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    return {a, b};
  endfunction

  function automatic logic [79:0] rnd80();
    logic [31:0] a, b, c;
    a = $urandom;
    b = $urandom;
    c = $urandom;
    return {a[15:0], b, c};
  endfunction

  logic [63:0] x;
  logic [79:0] k;
  logic [63:0] held;

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0] = '{64'h0, 80'h0, 64'hAAAAAAAAAAAAAAAA};
    vecs[1] = '{64'h0, 80'h0000FFFFFFFFFFFFFFFF, 64'h5555555555555555};
    vecs[2] = '{64'h0, 80'hFFFF0000000000000000, 64'hAAAAAAAAAAAAAAAA};
    vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 80'h0, 64'hAABBAABBAABBAABB};
    vecs[4] = '{64'h0000000000000001, 80'h0, 64'hCAAAAAA9AAAAAAAA};

    // Reset held with busy inputs
    rst_n        = 1'b0;
    in_valid     = 1'b1;
    Current_Text = 64'h0123456789ABCDEF;
    Key          = 80'h1234_5678_9ABC_DEF0_1357;
    #2;
    chk64("reset_text_async", Updated_Text, 64'h0);
    chk1("reset_valid_async", out_valid, 1'b0);
    tick();
    tick();
    chk64("reset_text_held", Updated_Text, 64'h0);
    chk1("reset_valid_held", out_valid, 1'b0);

    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    chk64("post_reset_idle_text", Updated_Text, 64'h0);
    chk1("post_reset_idle_valid", out_valid, 1'b0);

    // Directed vectors, one cycle each
    for (int i = 0; i < 5; i++) begin
      Current_Text = vecs[i].text;
      Key          = vecs[i].key;
      in_valid     = 1'b1;
      tick();
      chk64($sformatf("vec%0d_text", i), Updated_Text, vecs[i].exp);
      chk1($sformatf("vec%0d_valid", i), out_valid, 1'b1);
    end

    // Output holds when in_valid is low
    held         = Updated_Text;
    in_valid     = 1'b0;
    Current_Text = 64'hDEADBEEFCAFEF00D;
    Key          = 80'h0;
    tick();
    chk64("hold_text", Updated_Text, held);
    chk1("hold_valid", out_valid, 1'b0);
    tick();
    chk64("hold_text_2", Updated_Text, held);

    // Named round-trip pairs
    x            = rnd64();
    k            = 80'h497c41fec3b69bcbf171;
    Current_Text = encrypt(x, k);
    Key          = k;
    in_valid     = 1'b1;
    tick();
    chk64("rt_named_key", Updated_Text, x);
    x            = 64'h3bd8f07913e117f4;
    k            = 80'hef0e726f2fc5c524d10a;
    Current_Text = encrypt(x, k);
    Key          = k;
    tick();
    chk64("rt_named_text", Updated_Text, x);
    chk1("rt_named_valid", out_valid, 1'b1);

    // Back-to-back random round trips
    for (int i = 0; i < 1000; i++) begin
      x            = rnd64();
      k            = rnd80();
      Current_Text = encrypt(x, k);
      Key          = k;
      in_valid     = 1'b1;
      tick();
      chk64($sformatf("rt%0d_text", i), Updated_Text, x);
      chk1($sformatf("rt%0d_valid", i), out_valid, 1'b1);
    end

    // Reset asserted mid-stream, away from the clock edge
    rst_n = 1'b0;
    #1;
    chk64("midrst_text_async", Updated_Text, 64'h0);
    chk1("midrst_valid_async", out_valid, 1'b0);
    x            = rnd64();
    k            = rnd80();
    Current_Text = encrypt(x, k);
    Key          = k;
    tick();
    chk64("midrst_text_held", Updated_Text, 64'h0);
    chk1("midrst_valid_held", out_valid, 1'b0);

    rst_n        = 1'b1;
    x            = 64'h0F1E2D3C4B5A6978;
    k            = 80'hA5A5_0011_2233_4455_6677;
    Current_Text = encrypt(x, k);
    Key          = k;
    tick();
    chk64("first_after_rst_text", Updated_Text, x);
    chk1("first_after_rst_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    tick();
    chk1("tail_valid", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
